i2c_slave_byte_engine: RTL

Clocked I2C slave protocol engine for the EEPROM slave. Sits directly downstream of `start_stop_logic`: it consumes that block's START/STOP flags plus the raw SCL/SDA pads, deserialises address and data bytes, matches the device address, drives ACK and read data onto SDA, and hands bytes to and from the Avalon-side EEPROM storage logic through a simple valid/request interface.

---
 rtl/i2c_pkg.sv | 31 +++
 rtl/i2c_sync_edge.sv | 46 ++++
 rtl/i2c_slave_byte_engine.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared definitions for the I2C slave byte engine: FSM state
//                encoding and bus-level constants for ACK/NACK and R/W.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Protocol engine states. Explicit 3-bit encoding keeps the state
    // register width fixed regardless of tool enum handling.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_BYTE   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_BYTE   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } i2c_state_e;

    // SDA level seen during the acknowledge clock.
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;

    // Value of the R/W bit that requests a read.
    localparam logic I2C_RW_READ = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Multi-flop synchroniser for one asynchronous input, with
//                single-cycle rise/fall pulses derived from the synchronised
//                level.
//  Ports       : clk, reset_n (async active-low)
//                async_i  - raw asynchronous input
//                sync_o   - synchronised level
//                rise_o   - one-cycle pulse on synchronised 0->1
//                fall_o   - one-cycle pulse on synchronised 1->0
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
    parameter int   STAGES    = 2,
    // Idle level of the input; chosen so that leaving reset with the line
    // at its idle level produces no spurious edge.
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule : i2c_sync_edge
`default_nettype wire

// File: rtl/i2c_slave_byte_engine.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_slave_byte_engine
//  Description : I2C slave protocol engine for the EEPROM slave. Deserialises
//                address/data bytes, matches the device address, drives ACK
//                and read data on SDA (open-drain), and exchanges bytes with
//                the storage logic through a valid/request interface.
//  Ports       : clk, reset_n (async active-low)
//                scl, sda                       - raw bus pads (async)
//                start_detected, stop_detected  - bus condition flags (async)
//                sda_oe   - 1 pulls SDA low
//                rx_data/rx_valid/rx_first      - received write bytes
//                tx_req/tx_data                 - read byte request/return
//                rw       - R/W bit of current transaction
//                busy     - addressed and transfer in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_byte_engine
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    input  logic       sda,
    input  logic       start_detected,
    input  logic       stop_detected,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       rw,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Input synchronisers and edge pulses
    // ------------------------------------------------------------------
    logic w_scl_s, w_scl_rise, w_scl_fall;
    logic w_sda_s, w_sda_rise, w_sda_fall;
    logic w_start_s, w_start_p, w_start_fall;
    logic w_stop_s, w_stop_p, w_stop_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_scl (
        .clk(clk), .reset_n(reset_n), .async_i(scl),
        .sync_o(w_scl_s), .rise_o(w_scl_rise), .fall_o(w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sda (
        .clk(clk), .reset_n(reset_n), .async_i(sda),
        .sync_o(w_sda_s), .rise_o(w_sda_rise), .fall_o(w_sda_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_start (
        .clk(clk), .reset_n(reset_n), .async_i(start_detected),
        .sync_o(w_start_s), .rise_o(w_start_p), .fall_o(w_start_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_stop (
        .clk(clk), .reset_n(reset_n), .async_i(stop_detected),
        .sync_o(w_stop_s), .rise_o(w_stop_p), .fall_o(w_stop_fall)
    );

    // Levels and unused edges of the synchronisers are not needed here.
    logic w_unused;
    assign w_unused = ^{w_scl_s, w_sda_rise, w_sda_fall, w_start_s,
                        w_start_fall, w_stop_s, w_stop_fall};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_req_q, tx_req_d;
    logic       first_q, first_d;    // next write byte is the word address
    logic       ack_ph_q, ack_ph_d;  // 0: ACK not yet driven, 1: ACK driven
    logic       load_q, load_d;      // tx_data capture one cycle after tx_req

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_req_d   = 1'b0;
        first_d    = first_q;
        ack_ph_d   = ack_ph_q;
        load_d     = tx_req_q;

        // Read byte arrives two cycles after the request pulse; SCL timing
        // guarantees this lands well before the first SCL fall in RD_BYTE.
        if (load_q) begin
            shift_d = tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                sda_oe_d = 1'b0;
            end

            ST_ADDR: begin
                if (w_scl_rise) begin
                    shift_d = {shift_q[6:0], w_sda_s};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        ack_ph_d  = 1'b0;
                        state_d   = ST_ADDR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_ADDR_ACK: begin
                if (shift_q[7:1] != DEV_ADDR) begin
                    state_d = ST_WAIT_STOP;
                end else if (w_scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_oe_d  = 1'b1;
                        rw_d      = shift_q[0];
                        busy_d    = 1'b1;
                        first_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (shift_q[0] == I2C_RW_READ) begin
                            // The SCL fall that ends the ACK clock also
                            // presents the read MSB, so the read byte is
                            // requested now and RD_BYTE's first fall both
                            // releases the ACK and drives bit 7.
                            tx_req_d = 1'b1;
                            state_d  = ST_RD_BYTE;
                        end else begin
                            ack_ph_d = 1'b1;
                        end
                    end else begin
                        sda_oe_d = 1'b0;
                        ack_ph_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end
            end

            ST_WR_BYTE: begin
                if (w_scl_rise) begin
                    shift_d = {shift_q[6:0], w_sda_s};
                    if (bit_cnt_q == 4'd7) begin
                        rx_data_d  = {shift_q[6:0], w_sda_s};
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                        bit_cnt_d  = 4'd0;
                        ack_ph_d   = 1'b0;
                        state_d    = ST_WR_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_WR_ACK: begin
                if (w_scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        ack_ph_d = 1'b0;
                        state_d  = ST_WR_BYTE;
                    end
                end
            end

            ST_RD_BYTE: begin
                if (w_scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_ACK;
                    end else begin
                        sda_oe_d  = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_RD_ACK: begin
                if (w_scl_rise) begin
                    bit_cnt_d = 4'd0;
                    if (w_sda_s == I2C_ACK) begin
                        tx_req_d = 1'b1;
                        state_d  = ST_RD_BYTE;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_WAIT_STOP;
                    end
                end
            end

            ST_WAIT_STOP: begin
                sda_oe_d = 1'b0;
            end

            default: begin
                sda_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Bus conditions override everything; STOP is evaluated last so it
        // wins over a simultaneous START.
        if (w_start_p) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
        end
        if (w_stop_p) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
            sda_oe_d  = 1'b0;
            ack_ph_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            first_q    <= 1'b0;
            ack_ph_q   <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_first_q <= rx_first_d;
            tx_req_q   <= tx_req_d;
            first_q    <= first_d;
            ack_ph_q   <= ack_ph_d;
            load_q     <= load_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule : i2c_slave_byte_engine
`default_nettype wire
